// File: rtl/mem_access.sv
// Memory-access pipeline stage: turns the EX/MEM load/store into a single
// outstanding bus request, aligns store data and extends load data.
`ifndef RegDataWidth
`define RegDataWidth 32
`endif
`ifndef RegAddrWidth
`define RegAddrWidth 5
`endif

module mem_access (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 mem_op,
    input  logic [`RegDataWidth-1:0]   ALU_data,
    input  logic [`RegDataWidth-1:0]   store_data,
    input  logic [`RegAddrWidth-1:0]   target,
    input  logic                       WriteReg,
    input  logic                       MemOrAlu,
    input  logic                       we_hi,
    input  logic                       we_lo,
    input  logic [`RegDataWidth-1:0]   hi,
    input  logic [`RegDataWidth-1:0]   lo,
    input  logic                       hold_in,
    input  logic [`RegDataWidth-1:0]   bus_rdata,
    input  logic                       bus_ack,
    output logic [`RegDataWidth-1:0]   ALU_data_out,
    output logic [`RegAddrWidth-1:0]   target_out,
    output logic                       WriteReg_out,
    output logic                       MemOrAlu_out,
    output logic                       we_hi_out,
    output logic                       we_lo_out,
    output logic [`RegDataWidth-1:0]   hi_out,
    output logic [`RegDataWidth-1:0]   lo_out,
    output logic [`RegDataWidth-1:0]   MEM_data_out,
    output logic                       stall_req,
    output logic                       misalign_exc,
    output logic                       bus_req,
    output logic                       bus_we,
    output logic [`RegDataWidth-1:0]   bus_addr,
    output logic [3:0]                 bus_sel,
    output logic [`RegDataWidth-1:0]   bus_wdata
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  op_r;
    logic [1:0]  addr_lo_r;
    logic        is_mem_s;
    logic        is_store_s;
    logic        misalign_raw_s;
    logic        issue_s;
    logic        complete_s;

    function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] a);
        case (op)
            OP_LB, OP_LBU, OP_SB: lane_sel = 4'b0001 << a;
            OP_LH, OP_LHU, OP_SH: lane_sel = a[1] ? 4'b1100 : 4'b0011;
            OP_LW, OP_SW:         lane_sel = 4'b1111;
            default:              lane_sel = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [3:0] op, input logic [31:0] d);
        case (op)
            OP_SB:   lane_wdata = {4{d[7:0]}};
            OP_SH:   lane_wdata = {2{d[15:0]}};
            OP_SW:   lane_wdata = d;
            default: lane_wdata = 32'd0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: is_misaligned = a[0];
            OP_LW, OP_SW:         is_misaligned = (a != 2'b00);
            default:              is_misaligned = 1'b0;
        endcase
    endfunction

    // Stores fall to the default arm, so they complete with a zero result.
    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] a,
                                                 input logic [31:0] rdata);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = rdata[{a, 3'b000} +: 8];
        half_v = rdata[{a[1], 4'b0000} +: 16];
        case (op)
            OP_LB:   load_extract = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_extract = {24'd0, byte_v};
            OP_LH:   load_extract = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_extract = {16'd0, half_v};
            OP_LW:   load_extract = rdata;
            default: load_extract = 32'd0;
        endcase
    endfunction

    assign ALU_data_out = ALU_data;
    assign target_out   = target;
    assign WriteReg_out = WriteReg & ~misalign_exc;
    assign MemOrAlu_out = MemOrAlu;
    assign we_hi_out    = we_hi;
    assign we_lo_out    = we_lo;
    assign hi_out       = hi;
    assign lo_out       = lo;

    // Decode of the operation currently presented by EX/MEM.
    always_comb begin
        is_mem_s       = (mem_op >= OP_LB) && (mem_op <= OP_SW);
        is_store_s     = (mem_op >= OP_SB) && (mem_op <= OP_SW);
        misalign_raw_s = is_misaligned(mem_op, ALU_data[1:0]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, stall and exception decode.
    always_comb begin
        state_nxt_s  = state_r;
        stall_req    = 1'b0;
        misalign_exc = 1'b0;
        issue_s      = 1'b0;
        complete_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (is_mem_s && misalign_raw_s) begin
                    misalign_exc = 1'b1;
                    state_nxt_s  = IDLE;
                end else if (is_mem_s) begin
                    stall_req   = 1'b1;
                    issue_s     = 1'b1;
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                if (bus_ack) begin
                    complete_s  = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                if (hold_in) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Bus request registers and load result; the low address bits are kept
    // so extraction uses the issued address, not whatever EX/MEM holds now.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'd0;
            bus_sel      <= 4'b0000;
            bus_wdata    <= 32'd0;
            MEM_data_out <= 32'd0;
            op_r         <= 4'd0;
            addr_lo_r    <= 2'b00;
        end else if (issue_s) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store_s;
            bus_addr  <= {ALU_data[31:2], 2'b00};
            bus_sel   <= lane_sel(mem_op, ALU_data[1:0]);
            bus_wdata <= lane_wdata(mem_op, store_data);
            op_r      <= mem_op;
            addr_lo_r <= ALU_data[1:0];
        end else if (complete_s) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_sel      <= 4'b0000;
            MEM_data_out <= load_extract(op_r, addr_lo_r, bus_rdata);
        end else begin
            bus_req <= bus_req;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized
// operations compared against a behavioural model of the memory stage.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_op;
    logic [31:0] ALU_data, store_data, hi, lo, bus_rdata;
    logic [4:0]  target;
    logic        WriteReg, MemOrAlu, we_hi, we_lo, hold_in, bus_ack;
    logic [31:0] ALU_data_out, hi_out, lo_out, MEM_data_out, bus_addr, bus_wdata;
    logic [4:0]  target_out;
    logic        WriteReg_out, MemOrAlu_out, we_hi_out, we_lo_out;
    logic        stall_req, misalign_exc, bus_req, bus_we;
    logic [3:0]  bus_sel;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_mem_data = 32'd0;

    mem_access dut (
        .clk(clk), .rst(rst), .mem_op(mem_op), .ALU_data(ALU_data),
        .store_data(store_data), .target(target), .WriteReg(WriteReg),
        .MemOrAlu(MemOrAlu), .we_hi(we_hi), .we_lo(we_lo), .hi(hi), .lo(lo),
        .hold_in(hold_in), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .ALU_data_out(ALU_data_out), .target_out(target_out),
        .WriteReg_out(WriteReg_out), .MemOrAlu_out(MemOrAlu_out),
        .we_hi_out(we_hi_out), .we_lo_out(we_lo_out), .hi_out(hi_out),
        .lo_out(lo_out), .MEM_data_out(MEM_data_out), .stall_req(stall_req),
        .misalign_exc(misalign_exc), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_is_mem(int op);
        return (op >= 1) && (op <= 8);
    endfunction

    function automatic bit m_misaligned(int op, logic [31:0] a);
        if (op == 3 || op == 4 || op == 7) return (a % 2) != 0;
        if (op == 5 || op == 8) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_sel(int op, logic [31:0] a);
        if (op == 1 || op == 2 || op == 6) return 32'd1 << (a % 4);
        if (op == 3 || op == 4 || op == 7) return ((a % 4) >= 2) ? 32'd12 : 32'd3;
        if (op == 5 || op == 8) return 32'd15;
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_wdata(int op, logic [31:0] d);
        if (op == 6) return (d % 256) * 32'h01010101;
        if (op == 7) return (d % 65536) * 32'h00010001;
        if (op == 8) return d;
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_load(int op, logic [31:0] a, logic [31:0] r);
        logic [31:0] b, h;
        b = (r >> (8 * (a % 4))) % 256;
        h = (r >> (16 * ((a / 2) % 2))) % 65536;
        if (op == 1) return (b >= 128) ? b + 32'hFFFFFF00 : b;
        if (op == 2) return b;
        if (op == 3) return (h >= 32768) ? h + 32'hFFFF0000 : h;
        if (op == 4) return h;
        if (op == 5) return r;
        return 32'd0;
    endfunction

    // One EX/MEM operation: issue, 'waits' cycles without ack, ack, DONE
    // extended by 'holds' cycles of hold_in.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int waits, input int holds);
        bit mis;
        logic wr;
        mis = m_is_mem(op) && m_misaligned(op, addr);
        wr  = 1'($urandom_range(0, 1));
        @(negedge clk);
        mem_op = op; ALU_data = addr; store_data = sdata; WriteReg = wr;
        target = 5'($urandom); MemOrAlu = 1'($urandom); we_hi = 1'($urandom);
        we_lo = 1'($urandom); hi = $urandom; lo = $urandom;
        hold_in = 1'b0; bus_ack = 1'b0;
        #1;
        check_val("pass_alu", ALU_data_out, addr);
        check_val("pass_misc", {target_out, MemOrAlu_out, we_hi_out, we_lo_out},
                  {target, MemOrAlu, we_hi, we_lo});
        check_val("pass_hilo", hi_out ^ lo_out, hi ^ lo);
        check_val("misalign", misalign_exc, mis);
        check_val("writereg_gate", WriteReg_out, wr & ~mis);
        check_val("idle_stall", stall_req, m_is_mem(op) && !mis);
        if (!m_is_mem(op) || mis) begin
            @(negedge clk); #1;
            check_val("no_req", bus_req, 1'b0);
            check_val("no_req_stall", stall_req, 1'b0);
            check_val("mem_data_kept", MEM_data_out, exp_mem_data);
            mem_op = 4'd0;
            return;
        end
        for (int w = 0; w <= waits; w++) begin
            @(negedge clk);
            ALU_data = $urandom;
            bus_ack = (w == waits);
            bus_rdata = (w == waits) ? rdata : $urandom;
            #1;
            check_val("busy_stall", stall_req, 1'b1);
            check_val("bus_req", bus_req, 1'b1);
            check_val("bus_we", bus_we, op >= 4'd6);
            check_val("bus_addr", bus_addr, addr & 32'hFFFFFFFC);
            check_val("bus_sel", bus_sel, m_sel(op, addr));
            check_val("bus_wdata", bus_wdata, m_wdata(op, sdata));
        end
        exp_mem_data = m_load(op, addr, rdata);
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = $urandom; ALU_data = addr;
        hold_in = (holds > 0);
        #1;
        check_val("done_stall", stall_req, 1'b0);
        check_val("done_req", {bus_req, bus_we, bus_sel}, 32'd0);
        check_val("mem_data", MEM_data_out, exp_mem_data);
        for (int h = 1; h <= holds; h++) begin
            @(negedge clk);
            hold_in = (h < holds);
            #1;
            check_val("hold_stall", stall_req, 1'b0);
            check_val("hold_req", bus_req, 1'b0);
            check_val("hold_data", MEM_data_out, exp_mem_data);
        end
        @(negedge clk); #1;
        check_val("back_idle_stall", stall_req, 1'b1);
        check_val("back_idle_req", bus_req, 1'b0);
        mem_op = 4'd0;
        #1;
        check_val("idle_noop_stall", stall_req, 1'b0);
    endtask

    initial begin
        rst = 1'b1; mem_op = 4'd0; ALU_data = 32'd0; store_data = 32'd0;
        target = 5'd0; WriteReg = 1'b0; MemOrAlu = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
        hi = 32'd0; lo = 32'd0; hold_in = 1'b0; bus_rdata = 32'd0; bus_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_req", {bus_req, bus_we, bus_sel}, 32'd0);
        check_val("rst_addr", bus_addr, 32'd0);
        check_val("rst_wdata", bus_wdata, 32'd0);
        check_val("rst_data", MEM_data_out, 32'd0);
        check_val("rst_stall", stall_req, 1'b0);
        rst = 1'b0;

        // Reset while BUSY, followed by a late ack.
        mem_op = 4'd5; ALU_data = 32'h0000_0200;
        @(negedge clk); #1;
        check_val("rb_req", bus_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_op = 4'd0; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        #1;
        check_val("rb_req_drop", bus_req, 1'b0);
        check_val("rb_stall", stall_req, 1'b0);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check_val("rb_late_ack_req", bus_req, 1'b0);
        check_val("rb_late_ack_data", MEM_data_out, 32'd0);
        check_val("rb_late_ack_stall", stall_req, 1'b0);

        // Directed cases.
        run_op(4'd5, 32'h0000_0100, 32'd0,          32'hDEAD_BEEF, 0, 0);
        run_op(4'd1, 32'h0000_0103, 32'd0,          32'h8000_0000, 3, 0);
        run_op(4'd2, 32'h0000_0103, 32'd0,          32'h8000_0000, 3, 0);
        run_op(4'd6, 32'h0000_0002, 32'h0000_0012,  32'hFFFF_FFFF, 0, 0);
        run_op(4'd7, 32'h0000_0006, 32'h0000_ABCD,  32'hFFFF_FFFF, 1, 0);
        run_op(4'd5, 32'h0000_0102, 32'd0,          32'd0,         0, 0);
        run_op(4'd3, 32'h0000_0042, 32'd0,          32'h8001_7FFF, 0, 2);
        run_op(4'd0, 32'h0000_0010, 32'd0,          32'd0,         0, 0);

        // Randomized operations.
        for (int i = 0; i < 80; i++) begin
            run_op(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
